// File: rtl/btn_defs.sv
// ---------------------------------------------------------------------------
// btn_defs
// Shared definitions for the button debouncer slice.
// Holds only the per-channel auto-repeat state encoding.
// ---------------------------------------------------------------------------
package btn_defs;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

endpackage : btn_defs

// File: rtl/btn_debounce_ch.sv
// ---------------------------------------------------------------------------
// btn_debounce_ch
// One button channel: 2-flop synchroniser, debounce counter, auto-repeat FSM
// and the press/repeat event pulse.
//
// Ports
//   clock    in   rising-edge clock
//   reset    in   asynchronous active-high reset
//   btn_raw  in   raw asynchronous button level, 1 = pressed
//   stable   out  debounced level
//   evt      out  one-cycle event: high during the cycle whose closing edge
//                 accepts a press or fires a repeat
// ---------------------------------------------------------------------------
module btn_debounce_ch
  import btn_defs::*;
#(
  parameter int STABLE_CLKS   = 4096,
  parameter int CNT_W         = 16,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 65535,
  parameter int REPEAT_PERIOD = 16384
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  output logic stable,
  output logic evt
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CLKS - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic             sync_p0_q, sync_p0_d;
  logic             sync_p1_q, sync_p1_d;
  logic             cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  rep_state_e       state_q, state_d;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic             press;
  logic             rep;

  // Increment that parks at the terminal value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    sat_inc = (v >= lim) ? lim : v + CNT_W'(1);
  endfunction

  // Synchroniser stage
  always_comb begin
    sync_p0_d = btn_raw;
    sync_p1_d = sync_p0_q;
  end

  // Debounce stage: cand tracks the latest synchronised level, cnt counts
  // how long it has agreed. The counter keeps cycling while the level is
  // steady, which just rewrites stable with the value it already holds.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_p1_q != cand_q) begin
      cand_d = sync_p1_q;
      cnt_d  = '0;
    end else if (cnt_q == STABLE_LAST) begin
      stable_d = cand_q;
      cnt_d    = '0;
    end else begin
      cnt_d = sat_inc(cnt_q, STABLE_LAST);
    end
    press = stable_d & ~stable_q;
  end

  // Repeat stage: keyed on the next stable value so a release never fires a
  // repeat on the same edge it is accepted.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    rep     = 1'b0;
    if (!stable_d) begin
      state_d = ST_IDLE;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press) begin
            state_d = ST_HELD;
            rcnt_d  = '0;
          end
        end
        ST_HELD: begin
          // Without auto-repeat the channel parks here with rcnt at 0.
          if (REPEAT_EN != 0) begin
            if (rcnt_q == DELAY_LAST) begin
              rep     = 1'b1;
              state_d = ST_REPEAT;
              rcnt_d  = '0;
            end else begin
              rcnt_d = sat_inc(rcnt_q, DELAY_LAST);
            end
          end
        end
        ST_REPEAT: begin
          if (rcnt_q == PERIOD_LAST) begin
            rep    = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = sat_inc(rcnt_q, PERIOD_LAST);
          end
        end
        default: begin
          state_d = ST_IDLE;
          rcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0_q <= 1'b0;
      sync_p1_q <= 1'b0;
      cand_q    <= 1'b0;
      cnt_q     <= '0;
      stable_q  <= 1'b0;
      state_q   <= ST_IDLE;
      rcnt_q    <= '0;
    end else begin
      sync_p0_q <= sync_p0_d;
      sync_p1_q <= sync_p1_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
    end
  end

  assign stable = stable_q;
  assign evt    = press | rep;

endmodule : btn_debounce_ch

// File: rtl/btn_debounce_n.sv
// ---------------------------------------------------------------------------
// btn_debounce_n
// N_BTN independent debounced buttons with optional auto-repeat, read out
// through a one-cycle request/done handshake.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   start_port  in   one-cycle read request
//   btn         in   [N_BTN-1:0] raw button levels, 1 = pressed
//   out1        out  [N_BTN-1:0] debounced levels,
//                    [2*N_BTN-1:N_BTN] press-event flags since last read
//   done_port   out  high for the cycle after a read; out1 holds that read
// ---------------------------------------------------------------------------
module btn_debounce_n
  import btn_defs::*;
#(
  parameter int N_BTN         = 4,
  parameter int STABLE_CLKS   = 4096,
  parameter int CNT_W         = 16,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 65535,
  parameter int REPEAT_PERIOD = 16384
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start_port,
  input  logic [N_BTN-1:0]   btn,
  output logic [2*N_BTN-1:0] out1,
  output logic               done_port
);

  logic [N_BTN-1:0]   stable;
  logic [N_BTN-1:0]   evt;
  logic [N_BTN-1:0]   flag_q, flag_d;
  logic [2*N_BTN-1:0] out1_q, out1_d;
  logic               done_q, done_d;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CLKS  (STABLE_CLKS),
      .CNT_W        (CNT_W),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clock  (clock),
      .reset  (reset),
      .btn_raw(btn[i]),
      .stable (stable[i]),
      .evt    (evt[i])
    );
  end

  // Read stage: a read snapshots the flags it reports and clears them;
  // an event landing on the same edge is OR-ed in afterwards so it survives.
  always_comb begin
    flag_d = flag_q;
    out1_d = out1_q;
    done_d = start_port;
    if (start_port) begin
      out1_d = {flag_q, stable};
      flag_d = '0;
    end
    flag_d = flag_d | evt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flag_q <= '0;
      out1_q <= '0;
      done_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
      out1_q <= out1_d;
      done_q <= done_d;
    end
  end

  assign out1      = out1_q;
  assign done_port = done_q;

endmodule : btn_debounce_n

// File: doc/btn_debounce_n.md
BTN_DEBOUNCE_N -- requirements
Module: btn_debounce_n

Interface
REQ-001 SHALL have parameter N_BTN, default 4: number of independent button channels, range 1..16.
REQ-002 SHALL have parameter STABLE_CLKS, default 4096: consecutive equal samples required to accept a new level, range 2..2^CNT_W.
REQ-003 SHALL have parameter CNT_W, default 16: width of each debounce and repeat counter.
REQ-004 SHALL have parameter REPEAT_EN, default 0: 1 enables auto-repeat press events while a button is held.
REQ-005 SHALL have parameter REPEAT_DELAY, default 65535: held clocks after an accepted press before the first repeat event.
REQ-006 SHALL have parameter REPEAT_PERIOD, default 16384: clocks between subsequent repeat events.
REQ-007 SHALL have port clock, input, 1 bit: the single clock; all flops on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port start_port, input, 1 bit: one-cycle read request.
REQ-010 SHALL have port btn, input, N_BTN bits: raw asynchronous button levels, 1 = pressed.
REQ-011 SHALL have port out1, output, 2*N_BTN bits: [N_BTN-1:0] debounced levels, [2*N_BTN-1:N_BTN] pending press-event flags.
REQ-012 SHALL have port done_port, output, 1 bit: out1 valid for the read just serviced.

Function
REQ-013 Each btn bit SHALL pass through a 2-flop synchroniser before any other logic.
REQ-014 Per channel: if sync == cand, cnt increments; at cnt == STABLE_CLKS-1, stable <= cand and cnt <= 0. If sync != cand, cand <= sync and cnt <= 0.
REQ-015 A clean btn level change SHALL reach stable exactly STABLE_CLKS+3 rising edges after the first edge that samples it; any glitch shorter than STABLE_CLKS cycles SHALL never change stable.
REQ-016 A stable 0->1 transition SHALL set that channel's event flag; a 1->0 transition SHALL set nothing.
REQ-017 Per-channel repeat FSM: IDLE (stable=0); on a press go to HELD and load rcnt=0. HELD: at rcnt == REPEAT_DELAY-1, set the event flag, go to REPEAT, and rcnt <= 0. REPEAT: at rcnt == REPEAT_PERIOD-1, set the event flag and rcnt <= 0. From any state, stable=0 returns to IDLE.
REQ-018 With REPEAT_EN=0, the FSM SHALL stay in IDLE/HELD and never generate repeat events.
REQ-019 When start_port=1 at edge k, out1 SHALL be updated at edge k with {flags, stable} as they were before edge k; done_port SHALL be 1 for exactly the cycle following edge k.
REQ-020 A read SHALL clear exactly the flags it reported; an event arriving at the same edge SHALL remain set (set wins over clear).
REQ-021 Without start_port, out1 SHALL hold its last value and done_port SHALL be 0.
REQ-022 Back-to-back start_port cycles SHALL each be serviced; the second read returns only events that arrived after the first.
REQ-023 Event flags SHALL saturate at 1; multiple presses between reads collapse into one flag.
REQ-024 The counters SHALL never wrap: cnt is bounded by STABLE_CLKS-1 and rcnt by max(REPEAT_DELAY, REPEAT_PERIOD)-1.

Reset
REQ-025 Reset asserted SHALL immediately force sync, cand, cnt, stable, rcnt, flags, out1 and done_port to 0, and every FSM to IDLE.
REQ-026 Reset mid-debounce or mid-read SHALL discard all pending state; a button held through reset SHALL be re-accepted as a new press STABLE_CLKS+3 edges after reset deasserts.

Structure
REQ-027 The FSM state encodings (IDLE=0, HELD=1, REPEAT=2) SHALL live in the shared btn_defs include/package; no other constants go there.
REQ-028 One sub-module, btn_debounce_ch, SHALL implement the synchroniser, debounce counter, repeat FSM and press pulse for one channel; it SHALL be instantiated N_BTN times by generate.
REQ-029 The top level SHALL own only the flags, out1, done_port and the read logic.

Verification (STABLE_CLKS=8, REPEAT_DELAY=20, REPEAT_PERIOD=5, N_BTN=4)
REQ-030 btn=0001 held -> stable bit0=1 exactly 11 edges later; a subsequent read returns out1=8'b0001_0001, and the next read returns 8'b0000_0001.
REQ-031 btn bit1 toggled with 3-cycle pulses for 100 cycles -> stable bit1=0 throughout and no flag set.
REQ-032 REPEAT_EN=1, bit2 held 40 cycles after acceptance -> events at held cycles 20, 25, 30, 35, 40; a read after every event returns flag bit2=1.
REQ-033 A press event and start_port on the same edge -> that read shows flag=0, the next read shows flag=1.
REQ-034 reset pulsed while cnt=5 with btn=1111 -> all outputs are 0 immediately; stable=1111 exactly 11 edges after release, and all four flags are set.
REQ-035 start_port on two consecutive cycles with no new events -> done_port=1 for 2 cycles, and the second out1 has a zero flag field.
